// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the MEM stage and a host port.
// Round-robin grant with a host lock for bursts; read data returns one cycle after grant.
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              cpu_ren,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic              host_lock,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

    owner_t last_win;
    owner_t rd_owner;
    logic   lock_q;
    logic   rd_pend;

    logic   cpu_act;
    logic   host_act;
    logic   cpu_win;
    logic   host_win;

    // Grant decision and memory port steering
    always_comb begin
        cpu_act   = cpu_ren | cpu_wen;
        host_act  = host_req;
        host_win  = 1'b0;
        cpu_win   = 1'b0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        host_win = host_act & (~cpu_act | lock_q | (last_win == OWN_CPU));
        cpu_win  = cpu_act & ~host_win;

        if (host_win) begin
            mem_ren   = ~host_we;
            mem_wen   = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end else if (cpu_win) begin
            // a simultaneous read+write request is a write
            mem_ren   = cpu_ren & ~cpu_wen;
            mem_wen   = cpu_wen;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end

        cpu_stall = cpu_act & ~cpu_win;
        host_gnt  = host_win;
    end

    // Arbitration history and read-return tracking
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            last_win <= OWN_HOST;
            lock_q   <= 1'b0;
            rd_pend  <= 1'b0;
            rd_owner <= OWN_CPU;
        end else begin
            if (host_win) begin
                last_win <= OWN_HOST;
            end else if (cpu_win) begin
                last_win <= OWN_CPU;
            end
            lock_q   <= host_lock & host_win;
            rd_pend  <= mem_ren;
            rd_owner <= host_win ? OWN_HOST : OWN_CPU;
        end
    end

    assign cpu_rvalid  = rd_pend & (rd_owner == OWN_CPU);
    assign host_rvalid = rd_pend & (rd_owner == OWN_HOST);
    assign cpu_rdata   = mem_rdata;
    assign host_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios, a memory behind the port, and a
// per-cycle reference of who should own the memory and which read returns when.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        arst_n = 1'b1;
    logic        cpu_ren = 1'b0, cpu_wen = 1'b0;
    logic [63:0] cpu_addr = '0, cpu_wdata = '0;
    logic        cpu_stall, cpu_rvalid;
    logic [63:0] cpu_rdata;
    logic        host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
    logic [63:0] host_addr = '0, host_wdata = '0;
    logic        host_gnt, host_rvalid;
    logic [63:0] host_rdata;
    logic        mem_ren, mem_wen;
    logic [63:0] mem_addr, mem_wdata;
    logic [63:0] mem_rdata = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .arst_n(arst_n),
        .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_lock(host_lock),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [63:0] init_val(input logic [4:0] idx);
        case (idx)
            5'd0:    return 64'h11;
            5'd1:    return 64'h22;
            5'd2:    return 64'hDEAD;
            5'd3:    return 64'h33;
            default: return 64'h1000 + 64'(idx);
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Memory attached to the DUT's memory port
    logic [63:0] bmem [32];
    logic [31:0] bwritten = '0;
    always @(posedge clk) begin
        if (mem_wen) begin
            bmem[mem_addr[7:3]]     <= mem_wdata;
            bwritten[mem_addr[7:3]] <= 1'b1;
        end
        if (mem_ren)
            mem_rdata <= bwritten[mem_addr[7:3]] ? bmem[mem_addr[7:3]] : init_val(mem_addr[7:3]);
    end

    // Reference: previous winner (1 = host), lock carried, one expected read return
    logic        m_last = 1'b1, m_lock = 1'b0, m_pend = 1'b0, m_owner = 1'b0;
    logic [63:0] m_pdata = '0;
    logic [63:0] rmem [32];
    logic [31:0] rwritten = '0;
    logic        n_last, n_lock, n_pend, n_owner, n_we;
    logic [63:0] n_pdata, n_wdata;
    logic [4:0]  n_idx;
    logic        ca, ha, wh, wc, e_ren, e_wen;
    logic [63:0] e_addr, e_wdata;

    always @(negedge clk) begin
        ca = cpu_ren | cpu_wen;
        ha = host_req;
        if (ca && ha) wh = m_lock ? 1'b1 : ~m_last;
        else          wh = ha;
        wc = ca && !wh;
        e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_wdata = '0;
        if (wh) begin
            e_ren = !host_we; e_wen = host_we; e_addr = host_addr; e_wdata = host_wdata;
        end else if (wc) begin
            e_wen = cpu_wen; e_ren = !cpu_wen; e_addr = cpu_addr; e_wdata = cpu_wdata;
        end
        chk("m_cpu_stall", cpu_stall, ca && !wc);
        chk("m_host_gnt", host_gnt, wh);
        chk("m_mem_ren", mem_ren, e_ren);
        chk("m_mem_wen", mem_wen, e_wen);
        chk("m_mem_addr", mem_addr, e_addr);
        if (wh || wc) chk("m_mem_wdata", mem_wdata, e_wdata);
        chk("m_cpu_rvalid", cpu_rvalid, m_pend && !m_owner);
        chk("m_host_rvalid", host_rvalid, m_pend && m_owner);
        if (m_pend && !m_owner) chk("m_cpu_rdata", cpu_rdata, m_pdata);
        if (m_pend && m_owner)  chk("m_host_rdata", host_rdata, m_pdata);
        n_last  = (wh || wc) ? wh : m_last;
        n_lock  = host_lock && wh;
        n_pend  = e_ren;
        n_owner = wh;
        n_idx   = e_addr[7:3];
        n_pdata = rwritten[n_idx] ? rmem[n_idx] : init_val(n_idx);
        n_we    = e_wen;
        n_wdata = e_wdata;
    end

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            m_last <= 1'b1; m_lock <= 1'b0; m_pend <= 1'b0; m_owner <= 1'b0;
        end else begin
            m_last <= n_last; m_lock <= n_lock; m_pend <= n_pend;
            m_owner <= n_owner; m_pdata <= n_pdata;
            if (n_we) begin
                rmem[n_idx]     <= n_wdata;
                rwritten[n_idx] <= 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_ren = 0; cpu_wen = 0; host_req = 0; host_we = 0; host_lock = 0;
        cpu_addr = '0; cpu_wdata = '0; host_addr = '0; host_wdata = '0;
    endtask

    int exp_g[7] = '{0, 1, 1, 1, 1, 0, 1};
    int k;
    int gcnt;

    initial begin
        #1 arst_n = 1'b0;
        @(negedge clk);
        chk("rst_cpu_stall", cpu_stall, 0);
        chk("rst_host_gnt", host_gnt, 0);
        chk("rst_mem_ren", mem_ren, 0);
        chk("rst_mem_wen", mem_wen, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_host_rvalid", host_rvalid, 0);
        tick();
        arst_n = 1'b1;

        // Contention right after reset: CPU first, host next
        cpu_ren = 1; cpu_addr = 64'h8;
        host_req = 1; host_we = 1; host_addr = 64'h20; host_wdata = 64'h55;
        @(negedge clk);
        chk("t2_c0_host_gnt", host_gnt, 0);
        chk("t2_c0_cpu_stall", cpu_stall, 0);
        chk("t2_c0_mem_addr", mem_addr, 64'h8);
        tick();
        cpu_ren = 0;
        @(negedge clk);
        chk("t2_c1_host_gnt", host_gnt, 1);
        chk("t2_c1_mem_wen", mem_wen, 1);
        chk("t2_c1_mem_addr", mem_addr, 64'h20);
        chk("t2_c1_cpu_rvalid", cpu_rvalid, 1);
        chk("t2_c1_cpu_rdata", cpu_rdata, 64'h22);
        tick();
        idle();

        // CPU-only read of 0x10
        cpu_ren = 1; cpu_addr = 64'h10;
        @(negedge clk);
        chk("t1_c0_cpu_stall", cpu_stall, 0);
        chk("t1_c0_mem_ren", mem_ren, 1);
        tick();
        idle();
        @(negedge clk);
        chk("t1_c1_cpu_rvalid", cpu_rvalid, 1);
        chk("t1_c1_cpu_rdata", cpu_rdata, 64'hDEAD);
        chk("t1_c1_host_rvalid", host_rvalid, 0);
        tick();

        // Host-only write so the next contention starts with the CPU
        host_req = 1; host_we = 1; host_addr = 64'h30; host_wdata = 64'h77;
        @(negedge clk);
        chk("t3_pre_host_gnt", host_gnt, 1);
        tick();
        idle();

        // Six cycles of continuous contention without lock
        gcnt = 0;
        for (int i = 0; i < 6; i++) begin
            cpu_ren = 1; cpu_addr = 64'h10;
            host_req = 1; host_we = 0; host_addr = 64'h18;
            @(negedge clk);
            chk("t3_host_gnt", host_gnt, 64'(i % 2));
            chk("t3_cpu_stall", cpu_stall, 64'(i % 2));
            gcnt += int'(host_gnt);
            tick();
        end
        chk("t3_gnt_count", 64'(gcnt), 3);
        idle();
        tick();

        // Locked host burst against continuous CPU reads
        k = 0;
        for (int c = 0; c < 7; c++) begin
            cpu_ren = 1; cpu_addr = 64'h10;
            host_req = (k < 5); host_we = 1; host_lock = (k < 3);
            host_addr = 64'h40 + 64'(8 * k); host_wdata = 64'h100 + 64'(k);
            @(negedge clk);
            chk("t4_host_gnt", host_gnt, 64'(exp_g[c]));
            chk("t4_cpu_stall", cpu_stall, 64'(exp_g[c]));
            if (exp_g[c] == 1) k++;
            tick();
        end
        idle();
        tick();

        // Alternating-owner reads
        host_req = 1; host_we = 0; host_addr = 64'h0;
        @(negedge clk);
        chk("t5_c0_host_gnt", host_gnt, 1);
        tick();
        idle();
        cpu_ren = 1; cpu_addr = 64'h8;
        @(negedge clk);
        chk("t5_c1_host_rvalid", host_rvalid, 1);
        chk("t5_c1_host_rdata", host_rdata, 64'h11);
        chk("t5_c1_cpu_rvalid", cpu_rvalid, 0);
        tick();
        idle();
        @(negedge clk);
        chk("t5_c2_cpu_rvalid", cpu_rvalid, 1);
        chk("t5_c2_cpu_rdata", cpu_rdata, 64'h22);
        chk("t5_c2_host_rvalid", host_rvalid, 0);
        tick();

        // Reset while a CPU read is pending
        cpu_ren = 1; cpu_addr = 64'h10;
        @(negedge clk);
        chk("t6_c0_mem_ren", mem_ren, 1);
        tick();
        idle();
        arst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_cpu_rvalid", cpu_rvalid, 0);
        chk("t6_rst_host_rvalid", host_rvalid, 0);
        tick();
        arst_n = 1'b1;
        cpu_ren = 1; cpu_addr = 64'h8;
        host_req = 1; host_we = 0; host_addr = 64'h18;
        @(negedge clk);
        chk("t6_c1_host_gnt", host_gnt, 0);
        chk("t6_c1_cpu_stall", cpu_stall, 0);
        chk("t6_c1_cpu_rvalid", cpu_rvalid, 0);
        tick();
        cpu_ren = 0;
        @(negedge clk);
        chk("t6_c2_host_gnt", host_gnt, 1);
        tick();
        idle();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
